// File: rtl/cart_ram_pkg.sv
// rtl/cart_ram_pkg.sv - shared types and constants for the cartridge RAM port
// FSM state encoding, default address width and request latencies.
package cart_ram_pkg;

  localparam int AW_DEFAULT = 14;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;
  localparam int PF_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cart_ram_bram.sv
// rtl/cart_ram_bram.sv - single-port 16-bit RAM with byte enables
// Registered read, one-cycle latency; contents are never reset.
module cart_ram_bram #(
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_d,
  output logic [15:0]   o_q
);

  logic [15:0] r_mem [0:(1<<AW)-1];
  logic [15:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        if (i_be[1]) r_mem[i_addr][15:8] <= i_d[15:8];
        if (i_be[0]) r_mem[i_addr][7:0]  <= i_d[7:0];
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cart_ram_port.sv
// rtl/cart_ram_port.sv - toggle-handshake cartridge RAM port
// Optional next-word read prefetch enabled by defining CART_RAM_PREFETCH_EN.
module cart_ram_port
  import cart_ram_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          res_n,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW:1]   port_a,
  input  logic          port_we,
  input  logic [1:0]    port_ds,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          busy
);

  state_t        r_state;
  logic          r_req_seen;
  logic          r_ack;
  logic          r_busy;
  logic [15:0]   r_q;

  logic [AW:1]   r_a;
  logic          r_we;
  logic [1:0]    r_ds;
  logic [15:0]   r_d;

  // RAM command is registered so both read and write hit the RAM one edge later
  logic          r_ram_en;
  logic          r_ram_we;
  logic [1:0]    r_ram_be;
  logic [AW-1:0] r_ram_addr;
  logic [15:0]   r_ram_d;
  logic [15:0]   w_ram_q;

  logic          w_capture;

  assign w_capture = (r_state == ST_IDLE) && (port_req != r_req_seen);

`ifdef CART_RAM_PREFETCH_EN
  logic          r_pf_valid;
  logic          r_pf_pend;
  logic          r_pf_s1;
  logic          r_pf_s2;
  logic          r_hit;
  logic [AW:1]   r_pf_addr;
  logic [15:0]   r_pf_data;
  logic          w_pf_hit;

  assign w_pf_hit = r_pf_valid && !port_we && (port_a == r_pf_addr);
`endif

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      r_state    <= ST_IDLE;
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_q        <= 16'h0000;
      r_a        <= '0;
      r_we       <= 1'b0;
      r_ds       <= 2'b00;
      r_d        <= 16'h0000;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_be   <= 2'b00;
      r_ram_addr <= '0;
      r_ram_d    <= 16'h0000;
`ifdef CART_RAM_PREFETCH_EN
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
      r_pf_s1    <= 1'b0;
      r_pf_s2    <= 1'b0;
      r_hit      <= 1'b0;
      r_pf_addr  <= '0;
      r_pf_data  <= 16'h0000;
`endif
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_req_seen <= port_req;
            r_a        <= port_a;
            r_we       <= port_we;
            r_ds       <= port_ds;
            r_d        <= port_d;
            r_busy     <= 1'b1;
`ifdef CART_RAM_PREFETCH_EN
            // any new request abandons a fetch still in the pipe
            r_pf_pend  <= 1'b0;
            r_pf_s1    <= 1'b0;
            r_pf_s2    <= 1'b0;
            r_hit      <= 1'b0;
            if (port_we) begin
              if (port_a == r_pf_addr) r_pf_valid <= 1'b0;
              r_state <= ST_WR;
            end else if (w_pf_hit) begin
              r_hit   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RD1;
            end
`else
            r_state <= port_we ? ST_WR : ST_RD1;
`endif
          end
`ifdef CART_RAM_PREFETCH_EN
          else begin
            if (r_pf_pend) begin
              r_ram_en   <= 1'b1;
              r_ram_addr <= r_pf_addr;
            end
            r_pf_pend <= 1'b0;
            r_pf_s1   <= r_pf_pend;
            r_pf_s2   <= r_pf_s1;
            if (r_pf_s2) begin
              r_pf_data  <= w_ram_q;
              r_pf_valid <= 1'b1;
            end
          end
`endif
        end
        ST_RD1: begin
          r_ram_en   <= 1'b1;
          r_ram_addr <= r_a;
          r_state    <= ST_RD2;
        end
        ST_RD2: begin
          r_state <= ST_DONE;
        end
        ST_WR: begin
          r_ram_en   <= 1'b1;
          r_ram_we   <= 1'b1;
          r_ram_be   <= r_ds;
          r_ram_addr <= r_a;
          r_ram_d    <= r_d;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_ack   <= ~r_ack;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (!r_we) begin
`ifdef CART_RAM_PREFETCH_EN
            r_q        <= r_hit ? r_pf_data : w_ram_q;
            r_hit      <= 1'b0;
            r_pf_addr  <= r_a + AW'(1);
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b1;
`else
            r_q <= w_ram_q;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  cart_ram_bram #(
    .AW(AW)
  ) u_bram (
    .i_clk  (clk_sys),
    .i_en   (r_ram_en),
    .i_we   (r_ram_we),
    .i_be   (r_ram_be),
    .i_addr (r_ram_addr),
    .i_d    (r_ram_d),
    .o_q    (w_ram_q)
  );

  assign port_ack = r_ack;
  assign port_q   = r_q;
  assign busy     = r_busy;

endmodule

// File: doc/cart_ram_port.md
CART_RAM_PORT -- requirements
Module: cart_ram_port

Interface
REQ-001 The block SHALL have parameter AW, default 14, giving the word-address width; depth is 2^AW 16-bit words (32 KB at default).
REQ-002 The block SHALL have port clk_sys  input  1  the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port res_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port port_req  input  1  request toggle; a new request is pending whenever it differs from the internally recorded value.
REQ-005 The block SHALL have port port_ack  output  1  acknowledge toggle; it is inverted once per completed request.
REQ-006 The block SHALL have port port_a  input  AW (bits AW:1)  word address.
REQ-007 The block SHALL have port port_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port port_ds  input  2  byte lane enables: bit 1 = [15:8], bit 0 = [7:0].
REQ-009 The block SHALL have port port_d  input  16  write data.
REQ-010 The block SHALL have port port_q  output  16  read data, valid from the port_ack toggle onward.
REQ-011 The block SHALL have port busy  output  1  high while a captured request is outstanding.

Function
REQ-012 The block SHALL register req_seen and SHALL capture port_a, port_we, port_ds and port_d at any edge in IDLE where port_req != req_seen, setting req_seen to the sampled port_req at that edge.
REQ-013 The FSM SHALL use states IDLE, RD1, RD2, WR and DONE: IDLE->RD1 on a read capture, IDLE->WR on a write capture, RD1->RD2, RD2->DONE, WR->DONE, DONE->IDLE.
REQ-014 Read timing: with capture at edge N, RAM address at N+1, RAM data at N+2; port_q SHALL load and port_ack SHALL toggle at edge N+3.
REQ-015 Write timing: with capture at edge N, the byte-enabled RAM write AND the port_ack toggle SHALL both occur at edge N+2.
REQ-016 A write with port_ds=00 SHALL modify no memory and SHALL still be acknowledged with write timing.
REQ-017 Reads SHALL ignore port_ds and return the full word.
REQ-018 port_q SHALL hold the last read data; writes SHALL NOT change port_q.
REQ-019 If port_req toggles while busy, the block SHALL service the request after returning to IDLE, because req_seen then differs from port_req.
REQ-020 If port_req toggles twice while busy, the pair SHALL be treated as no request; this is a requester violation.
REQ-021 busy SHALL be high from the capture edge until the edge at which port_ack toggles.

Reset
REQ-022 While res_n=0, the block SHALL hold port_ack=0, req_seen=0, port_q=0, busy=0 and state=IDLE, and SHALL clear the prefetch-valid flag.
REQ-023 Reset SHALL NOT clear RAM contents.
REQ-024 Reset asserted before a WR write edge SHALL abort that write with no memory change and no acknowledge.

Configuration
REQ-025 With macro CART_RAM_PREFETCH_EN defined, each completed read at address A SHALL start a background fetch of A+1 (wrapping 2^AW-1 -> 0) in IDLE cycles, storing the word and its address and setting pf_valid.
REQ-026 With CART_RAM_PREFETCH_EN defined, a read captured at edge N that hits the prefetch address while pf_valid=1 SHALL load port_q and toggle port_ack at edge N+1, then start the next prefetch.
REQ-027 With CART_RAM_PREFETCH_EN defined, a write to the prefetch address SHALL clear pf_valid; a new capture SHALL abort any in-flight prefetch.
REQ-028 Without CART_RAM_PREFETCH_EN, no prefetch logic SHALL exist and all reads SHALL use the REQ-014 timing.

Structure
REQ-029 Package cart_ram_pkg SHALL hold the FSM state enum, default AW, and the latency constants RD_LAT=3, WR_LAT=2 and PF_LAT=1.
REQ-030 The RAM SHALL be sub-module cart_ram_bram: single-port, 16-bit wide, 2-bit byte enable, registered read, one-cycle latency.

Verification
REQ-031 Reset, then write 0xA55A to address 0x0010 with ds=11 -> ack toggles at N+2 and busy is high for 2 edges.
REQ-032 Read 0x0010 -> port_q=0xA55A and ack toggle at N+3; then write 0x1234 with ds=01 and read -> 0xA534.
REQ-033 Write with ds=00 to 0x0010 -> ack toggle and content unchanged (read returns 0xA534).
REQ-034 Toggle port_req once while busy with a read -> two acks total and the second request is serviced after DONE.
REQ-035 With prefetch: read 0x3FFF, idle 4 cycles, read 0x0000 -> ack at N+1; write 0x0000 then read 0x0000 -> ack at N+3 with new data.
REQ-036 Assert res_n=0 during WR -> target word unchanged, port_ack=0, port_q=0 and busy=0.
